// File: rtl/acq_sequencer.sv
// Acquisition sequencer: generator hop (outer), repetition (middle) and sample (inner) loops,
// with hop handshake, ADC capture window, progress pulses and a sticky error code.
module acq_sequencer #(
  parameter int CNT_W       = 24,
  parameter int SETTLE_CYC  = 16,
  parameter int HOP_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_trig,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] repetitions,
  input  logic [CNT_W-1:0] samples,
  input  logic [CNT_W-1:0] generator_hops,
  input  logic             gen_ready_i,
  input  logic             adc_valid_i,
  output logic             gen_hop_o,
  output logic [CNT_W-1:0] hop_idx_o,
  output logic [CNT_W-1:0] rep_idx_o,
  output logic             sample_en_o,
  output logic             rep_done_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_o,
  output logic [7:0]       led_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HOP_REQ  = 4'd1,
    S_HOP_WAIT = 4'd2,
    S_SETTLE   = 4'd3,
    S_CAPTURE  = 4'd4,
    S_GAP      = 4'd5,
    S_DONE     = 4'd6
  } state_t;

  localparam int TMR_W = $clog2(HOP_TIMEOUT + SETTLE_CYC + 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ZERO  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  state_t           state, state_next;
  logic [1:0]       err_q, err_next;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] lat_r, lat_s, lat_h;
  logic [CNT_W-1:0] samp_cnt, hop_idx, rep_idx;
  logic             rep_done_q;
  logic             cfg_zero, cap_last;

  assign cfg_zero = (repetitions == '0) || (samples == '0) || (generator_hops == '0);
  // Latched S is never zero while running, so S-1 cannot underflow.
  assign cap_last = (state == S_CAPTURE) && adc_valid_i && (samp_cnt == lat_s - CNT_W'(1));

  always_comb begin
    state_next = state;
    err_next   = err_q;
    case (state)
      S_IDLE: begin
        if (cpu_trig) begin
          if (cfg_zero) begin
            err_next = ERR_ZERO;
          end else begin
            err_next   = ERR_NONE;
            state_next = S_HOP_REQ;
          end
        end
      end
      S_HOP_REQ:  state_next = S_HOP_WAIT;
      S_HOP_WAIT: begin
        // Timer starts at 0 on the first wait cycle; idle lands HOP_TIMEOUT cycles after the request.
        if (gen_ready_i) begin
          state_next = S_SETTLE;
        end else if (tmr == TMR_W'(HOP_TIMEOUT - 2)) begin
          state_next = S_IDLE;
          err_next   = ERR_TMO;
        end
      end
      S_SETTLE: begin
        if (tmr == TMR_W'(SETTLE_CYC - 1)) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cap_last) begin
          if (rep_idx != lat_r - CNT_W'(1))      state_next = S_GAP;
          else if (hop_idx != lat_h - CNT_W'(1)) state_next = S_HOP_REQ;
          else                                   state_next = S_DONE;
        end
      end
      S_GAP:   state_next = S_CAPTURE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort_i && (state != S_IDLE)) begin
      state_next = S_IDLE;
      err_next   = ERR_ABORT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      err_q      <= ERR_NONE;
      tmr        <= '0;
      lat_r      <= '0;
      lat_s      <= '0;
      lat_h      <= '0;
      samp_cnt   <= '0;
      hop_idx    <= '0;
      rep_idx    <= '0;
      rep_done_q <= 1'b0;
    end else begin
      state      <= state_next;
      err_q      <= err_next;
      rep_done_q <= cap_last && !abort_i;

      if (state_next != state)
        tmr <= '0;
      else if ((state == S_HOP_WAIT) || (state == S_SETTLE))
        tmr <= tmr + TMR_W'(1);

      if ((state == S_IDLE) && cpu_trig) begin
        lat_r <= repetitions;
        lat_s <= samples;
        lat_h <= generator_hops;
      end

      if (state_next != S_CAPTURE)
        samp_cnt <= '0;
      else if ((state == S_CAPTURE) && adc_valid_i)
        samp_cnt <= samp_cnt + CNT_W'(1);

      if ((state == S_IDLE) && (state_next == S_HOP_REQ)) begin
        hop_idx <= '0;
        rep_idx <= '0;
      end else if ((state == S_CAPTURE) && (state_next == S_GAP)) begin
        rep_idx <= rep_idx + CNT_W'(1);
      end else if ((state == S_CAPTURE) && (state_next == S_HOP_REQ)) begin
        hop_idx <= hop_idx + CNT_W'(1);
        rep_idx <= '0;
      end
    end
  end

  assign gen_hop_o   = (state == S_HOP_REQ);
  assign sample_en_o = (state == S_CAPTURE);
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign rep_done_o  = rep_done_q;
  assign err_o       = err_q;
  assign hop_idx_o   = hop_idx;
  assign rep_idx_o   = rep_idx;
  assign led_o       = {busy_o, sample_en_o, err_q, 4'(state)};

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: loop totals, zero config, hop timeout, capture window shape,
// abort, ignored retrigger/config change and asynchronous reset.
module tb_acq_sequencer;

  localparam int CNT_W       = 24;
  localparam int SETTLE_CYC  = 16;
  localparam int HOP_TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cpu_trig, abort_i, gen_ready_i, adc_valid_i;
  logic [CNT_W-1:0] repetitions, samples, generator_hops;
  logic             gen_hop_o, sample_en_o, rep_done_o, busy_o, done_o;
  logic [CNT_W-1:0] hop_idx_o, rep_idx_o;
  logic [1:0]       err_o;
  logic [7:0]       led_o;

  int checks = 0;
  int errors = 0;

  // Stimulus controls (written only by the test sequence)
  int clr_req  = 0;
  int adc_mode = 0;  // 0: always valid, 1: toggle aligned to window start
  bit gen_auto = 1'b1;

  // Driver / monitor state (written only by the negedge process)
  int clr_seen = 0;
  int n_hop = 0, n_rep = 0, n_done = 0, n_samp = 0;
  int rdy_cnt = 0, hi_len = 0, lo_len = 0, lat_cnt = 0, last_lat = 0;
  bit lat_armed = 1'b0, prev_en = 1'b0, seen_high = 1'b0;
  int runs_hi[$];
  int runs_lo[$];

  acq_sequencer #(
    .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .HOP_TIMEOUT(HOP_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_trig(cpu_trig), .abort_i(abort_i),
    .repetitions(repetitions), .samples(samples), .generator_hops(generator_hops),
    .gen_ready_i(gen_ready_i), .adc_valid_i(adc_valid_i),
    .gen_hop_o(gen_hop_o), .hop_idx_o(hop_idx_o), .rep_idx_o(rep_idx_o),
    .sample_en_o(sample_en_o), .rep_done_o(rep_done_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .led_o(led_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- generator/ADC responder and event monitor ----------------
  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      n_hop = 0; n_rep = 0; n_done = 0; n_samp = 0;
      runs_hi.delete(); runs_lo.delete();
      seen_high = 1'b0; last_lat = 0; lat_armed = 1'b0;
      clr_seen = clr_req;
    end
    // Generator acknowledges two cycles after each hop request
    gen_ready_i = 1'b0;
    if (rdy_cnt > 0) begin
      rdy_cnt--;
      if ((rdy_cnt == 0) && gen_auto) gen_ready_i = 1'b1;
    end
    if (gen_hop_o) rdy_cnt = 2;
    if (adc_mode == 0) adc_valid_i = 1'b1;
    else               adc_valid_i = sample_en_o && ((hi_len % 2) == 0);
    if (sample_en_o && adc_valid_i) n_samp++;
    if (gen_hop_o)  n_hop++;
    if (rep_done_o) n_rep++;
    if (done_o)     n_done++;
    if (lat_armed) begin
      lat_cnt++;
      if (sample_en_o) begin last_lat = lat_cnt; lat_armed = 1'b0; end
    end
    if (gen_hop_o) begin lat_armed = 1'b1; lat_cnt = 0; end
    if (sample_en_o) begin
      if (!prev_en && seen_high) runs_lo.push_back(lo_len);
      hi_len++; lo_len = 0; seen_high = 1'b1;
    end else begin
      if (prev_en) runs_hi.push_back(hi_len);
      hi_len = 0; lo_len++;
    end
    prev_en = sample_en_o;
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input int h, input int r, input int s);
    clr_req++;
    @(negedge clk);
    generator_hops = CNT_W'(h);
    repetitions    = CNT_W'(r);
    samples        = CNT_W'(s);
    cpu_trig       = 1'b1;
    @(negedge clk);
    cpu_trig       = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy_o) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%0b after %0d cycles, required 0", name, busy_o, max_cyc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; cpu_trig = 1'b0; abort_i = 1'b0;
    repetitions = '0; samples = '0; generator_hops = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_o); end
    checks++; if (led_o !== 8'h00)   begin errors++; $display("FAIL reset_led got %02h exp 00", led_o); end
    checks++; if (err_o !== 2'b00)   begin errors++; $display("FAIL reset_err got %0b exp 00", err_o); end
    checks++; if ({gen_hop_o, sample_en_o, rep_done_o, done_o} !== 4'b0000)
      begin errors++; $display("FAIL reset_pulses got %04b exp 0000", {gen_hop_o, sample_en_o, rep_done_o, done_o}); end
    checks++; if ({hop_idx_o, rep_idx_o} !== '0)
      begin errors++; $display("FAIL reset_idx got hop=%0d rep=%0d exp 0 0", hop_idx_o, rep_idx_o); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_run;
    bit seen_en = 1'b0;
    adc_mode = 0; gen_auto = 1'b1;
    start_run(2, 3, 4);
    checks++; if (err_o !== 2'b00) begin errors++; $display("FAIL full_err_start got %0b exp 00", err_o); end
    checks++; if (gen_hop_o !== 1'b1) begin errors++; $display("FAIL full_hop_first got %0b exp 1", gen_hop_o); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sample_en_o) begin seen_en = 1'b1; break; end
    end
    checks++; if (!seen_en || led_o !== 8'hC4)
      begin errors++; $display("FAIL full_led_capture got %02h exp c4", led_o); end
    wait_idle(400, "full");
    checks++; if (n_hop != 2)  begin errors++; $display("FAIL full_hops got %0d exp 2", n_hop); end
    checks++; if (n_rep != 6)  begin errors++; $display("FAIL full_rep_done got %0d exp 6", n_rep); end
    checks++; if (n_samp != 24) begin errors++; $display("FAIL full_samples got %0d exp 24", n_samp); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL full_done got %0d exp 1", n_done); end
    checks++; if (err_o !== 2'b00) begin errors++; $display("FAIL full_err_end got %0b exp 00", err_o); end
    checks++; if (hop_idx_o !== 24'd1 || rep_idx_o !== 24'd2)
      begin errors++; $display("FAIL full_final_idx got hop=%0d rep=%0d exp 1 2", hop_idx_o, rep_idx_o); end
    // hop request, 2 wait cycles, SETTLE_CYC settle cycles, then capture
    checks++; if (last_lat != 3 + SETTLE_CYC)
      begin errors++; $display("FAIL full_hop_to_capture got %0d exp %0d", last_lat, 3 + SETTLE_CYC); end
  endtask

  task automatic test_zero_config;
    start_run(2, 0, 4);
    checks++; if (err_o !== 2'b01) begin errors++; $display("FAIL zero_r_err got %0b exp 01", err_o); end
    repeat (4) @(negedge clk);
    checks++; if (busy_o !== 1'b0 || n_hop != 0)
      begin errors++; $display("FAIL zero_r_idle got busy=%0b hops=%0d exp 0 0", busy_o, n_hop); end
    start_run(1, 1, 0);
    checks++; if (err_o !== 2'b01 || busy_o !== 1'b0)
      begin errors++; $display("FAIL zero_s got err=%0b busy=%0b exp 01 0", err_o, busy_o); end
    start_run(0, 5, 5);
    checks++; if (err_o !== 2'b01 || busy_o !== 1'b0)
      begin errors++; $display("FAIL zero_h got err=%0b busy=%0b exp 01 0", err_o, busy_o); end
  endtask

  task automatic test_timeout;
    gen_auto = 1'b0;
    start_run(1, 1, 1);
    checks++; if (gen_hop_o !== 1'b1) begin errors++; $display("FAIL tmo_hop got %0b exp 1", gen_hop_o); end
    repeat (HOP_TIMEOUT - 1) @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL tmo_early got busy=%0b exp 1", busy_o); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b0 || err_o !== 2'b10)
      begin errors++; $display("FAIL tmo_expire got busy=%0b err=%0b exp 0 10", busy_o, err_o); end
    checks++; if (n_done != 0) begin errors++; $display("FAIL tmo_done got %0d exp 0", n_done); end
    gen_auto = 1'b1;
  endtask

  task automatic test_toggle_valid;
    adc_mode = 1;
    start_run(1, 3, 5);
    wait_idle(400, "toggle");
    checks++; if (runs_hi.size() != 3)
      begin errors++; $display("FAIL toggle_windows got %0d exp 3", runs_hi.size()); end
    foreach (runs_hi[i]) begin
      checks++; if (runs_hi[i] != 9)
        begin errors++; $display("FAIL toggle_window_len[%0d] got %0d exp 9", i, runs_hi[i]); end
    end
    checks++; if (runs_lo.size() != 2)
      begin errors++; $display("FAIL toggle_gaps got %0d exp 2", runs_lo.size()); end
    foreach (runs_lo[i]) begin
      checks++; if (runs_lo[i] != 1)
        begin errors++; $display("FAIL toggle_gap_len[%0d] got %0d exp 1", i, runs_lo[i]); end
    end
    checks++; if (n_samp != 15 || n_rep != 3)
      begin errors++; $display("FAIL toggle_totals got samp=%0d rep=%0d exp 15 3", n_samp, n_rep); end
    adc_mode = 0;
  endtask

  task automatic test_abort;
    bit reached = 1'b0;
    start_run(1, 2, 100);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_samp >= 30) begin reached = 1'b1; break; end
    end
    checks++; if (!reached || sample_en_o !== 1'b1)
      begin errors++; $display("FAIL abort_reach got samp=%0d en=%0b exp 30 1", n_samp, sample_en_o); end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || err_o !== 2'b11 || sample_en_o !== 1'b0)
      begin errors++; $display("FAIL abort_next got busy=%0b err=%0b en=%0b exp 0 11 0", busy_o, err_o, sample_en_o); end
    checks++; if (led_o !== 8'h30) begin errors++; $display("FAIL abort_led got %02h exp 30", led_o); end
    repeat (2) @(negedge clk);
    checks++; if (n_done != 0 || n_rep != 0)
      begin errors++; $display("FAIL abort_pulses got done=%0d rep=%0d exp 0 0", n_done, n_rep); end
    abort_i = 1'b1;
    repeat (2) @(negedge clk);
    abort_i = 1'b0;
    checks++; if (err_o !== 2'b11 || busy_o !== 1'b0)
      begin errors++; $display("FAIL abort_idle got err=%0b busy=%0b exp 11 0", err_o, busy_o); end
    start_run(1, 1, 3);
    checks++; if (err_o !== 2'b00 || busy_o !== 1'b1)
      begin errors++; $display("FAIL abort_restart got err=%0b busy=%0b exp 00 1", err_o, busy_o); end
    wait_idle(200, "restart");
    checks++; if (n_done != 1 || n_samp != 3 || err_o !== 2'b00)
      begin errors++; $display("FAIL abort_restart_end got done=%0d samp=%0d err=%0b exp 1 3 00", n_done, n_samp, err_o); end
  endtask

  task automatic test_busy_ignore;
    start_run(2, 2, 3);
    repeat (5) @(negedge clk);
    generator_hops = 24'd7; repetitions = 24'd7; samples = 24'd7;
    cpu_trig = 1'b1;
    @(negedge clk);
    cpu_trig = 1'b0;
    wait_idle(400, "ignore");
    checks++; if (n_hop != 2 || n_rep != 4 || n_samp != 12 || n_done != 1)
      begin errors++; $display("FAIL ignore_totals got hop=%0d rep=%0d samp=%0d done=%0d exp 2 4 12 1", n_hop, n_rep, n_samp, n_done); end
    checks++; if (hop_idx_o !== 24'd1 || rep_idx_o !== 24'd1)
      begin errors++; $display("FAIL ignore_idx got hop=%0d rep=%0d exp 1 1", hop_idx_o, rep_idx_o); end
  endtask

  task automatic test_reset_mid_run;
    bit reached = 1'b0;
    start_run(2, 1, 2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hop_idx_o == 24'd1 && sample_en_o) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach got hop=%0d exp 1", hop_idx_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || sample_en_o !== 1'b0 || led_o !== 8'h00)
      begin errors++; $display("FAIL rstmid_outputs got busy=%0b en=%0b led=%02h exp 0 0 00", busy_o, sample_en_o, led_o); end
    checks++; if (hop_idx_o !== '0 || err_o !== 2'b00)
      begin errors++; $display("FAIL rstmid_state got hop=%0d err=%0b exp 0 00", hop_idx_o, err_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    gen_ready_i = 1'b0; adc_valid_i = 1'b0;
    test_reset();
    test_full_run();
    test_zero_config();
    test_timeout();
    test_toggle_valid();
    test_abort();
    test_busy_ignore();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
